// File: rtl/fifo_bundle_packer_if.sv
// Stream-side and FIFO-write-side signals of the bundle packer.
// The master modport is the environment that drives the packer; the slave modport is the packer.
interface fifo_bundle_packer_if #(
  parameter int DATAWIDTH = 192,
  parameter int PACK      = 6,
  parameter int CNT_WIDTH = $clog2(PACK + 1)
);
  logic [DATAWIDTH-1:0]      s_data;
  logic                      s_valid;
  logic                      s_ready;
  logic                      flush;
  logic [DATAWIDTH*PACK-1:0] wr_data;
  logic                      wr_valid;
  logic                      wr_full;
  logic [CNT_WIDTH-1:0]      wr_words;
  logic                      idle;

  modport master (
    output s_data, s_valid, flush, wr_full,
    input  s_ready, wr_data, wr_valid, wr_words, idle
  );

  modport slave (
    input  s_data, s_valid, flush, wr_full,
    output s_ready, wr_data, wr_valid, wr_words, idle
  );
endinterface

// File: rtl/fifo_bundle_packer.sv
// Packs PACK consecutive stream words into one bundle for the FIFO write port.
// A flush emits any partial bundle with its unused upper lanes zeroed.
module fifo_bundle_packer #(
  parameter int DATAWIDTH = 192,
  parameter int PACK      = 6,
  parameter int CNT_WIDTH = $clog2(PACK + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_bundle_packer_if.slave  bus
);
  localparam int                   BW     = DATAWIDTH * PACK;
  localparam logic [CNT_WIDTH-1:0] PACK_C = CNT_WIDTH'(PACK);

  logic [BW-1:0]        stg_q, stg_d;
  logic [CNT_WIDTH-1:0] stg_cnt_q, stg_cnt_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [BW-1:0]        out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] out_words_q, out_words_d;
  logic                 out_valid_q, out_valid_d;

  logic                 s_ready_s, accept_s, fire_s, slot_free_s, load_s;
  logic [CNT_WIDTH-1:0] cnt_after_s;
  logic [BW-1:0]        stg_next_s, stg_masked_s;

  assign s_ready_s = (stg_cnt_q < PACK_C) & ~flush_pend_q;

  // Next-state for staging, output register and flush tracking
  always_comb begin
    accept_s     = bus.s_valid & s_ready_s;
    fire_s       = out_valid_q & ~bus.wr_full;
    slot_free_s  = ~out_valid_q | fire_s;
    cnt_after_s  = stg_cnt_q + {{(CNT_WIDTH-1){1'b0}}, accept_s};
    stg_next_s   = stg_q;
    stg_masked_s = {BW{1'b0}};
    for (int i = 0; i < PACK; i++) begin
      if (accept_s && (stg_cnt_q == CNT_WIDTH'(i))) begin
        stg_next_s[i*DATAWIDTH +: DATAWIDTH] = bus.s_data;
      end else begin
        stg_next_s[i*DATAWIDTH +: DATAWIDTH] = stg_q[i*DATAWIDTH +: DATAWIDTH];
      end
      // Lanes beyond the live count may hold old words; they must leave as zero.
      if (CNT_WIDTH'(i) < cnt_after_s) begin
        stg_masked_s[i*DATAWIDTH +: DATAWIDTH] = stg_next_s[i*DATAWIDTH +: DATAWIDTH];
      end else begin
        stg_masked_s[i*DATAWIDTH +: DATAWIDTH] = {DATAWIDTH{1'b0}};
      end
    end

    // While a flush is pending s_ready is low, so cnt_after_s equals the staged count.
    load_s = slot_free_s &
             ((cnt_after_s == PACK_C) |
              (flush_pend_q & (cnt_after_s != {CNT_WIDTH{1'b0}})));

    stg_d = stg_next_s;
    if (load_s) begin
      stg_cnt_d = {CNT_WIDTH{1'b0}};
    end else begin
      stg_cnt_d = cnt_after_s;
    end

    if (load_s) begin
      out_data_d  = stg_masked_s;
      out_words_d = cnt_after_s;
      out_valid_d = 1'b1;
    end else if (fire_s) begin
      out_data_d  = out_data_q;
      out_words_d = out_words_q;
      out_valid_d = 1'b0;
    end else begin
      out_data_d  = out_data_q;
      out_words_d = out_words_q;
      out_valid_d = out_valid_q;
    end

    if (flush_pend_q) begin
      if ((stg_cnt_q == {CNT_WIDTH{1'b0}}) || load_s) begin
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else begin
      flush_pend_d = bus.flush;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q        <= {BW{1'b0}};
      stg_cnt_q    <= {CNT_WIDTH{1'b0}};
      flush_pend_q <= 1'b0;
      out_data_q   <= {BW{1'b0}};
      out_words_q  <= {CNT_WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
    end else begin
      stg_q        <= stg_d;
      stg_cnt_q    <= stg_cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_words_q  <= out_words_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.s_ready  = s_ready_s;
  assign bus.wr_data  = out_data_q;
  assign bus.wr_words = out_words_q;
  assign bus.wr_valid = out_valid_q;
  assign bus.idle     = (stg_cnt_q == {CNT_WIDTH{1'b0}}) & ~out_valid_q & ~flush_pend_q;
endmodule

// File: tb/tb_fifo_bundle_packer.sv
// Directed table, reset/flush sequences and a randomised scoreboard run
// for fifo_bundle_packer with PACK=3, DATAWIDTH=8.
module tb_fifo_bundle_packer;
  localparam int DW = 8;
  localparam int PK = 3;
  localparam int CW = 2;

  logic clk;
  logic rst_n;
  int   nchk;
  int   nerr;

  fifo_bundle_packer_if #(.DATAWIDTH(DW), .PACK(PK), .CNT_WIDTH(CW)) bus ();

  fifo_bundle_packer #(.DATAWIDTH(DW), .PACK(PK), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fl;
    logic        full;
    logic        e_rdy;
    logic        e_wv;
    logic [23:0] e_wd;
    logic [1:0]  e_ww;
    logic        e_idle;
  } vec_t;

  vec_t tbl[$];
  logic [7:0] exp_q[$];
  int   sent;
  logic hold_prev;
  logic [23:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic fl, input logic full);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.flush   = fl;
    bus.wr_full = full;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic fl, input logic full,
                     input logic rdy, input logic wv, input logic [23:0] wd,
                     input logic [1:0] ww, input logic idl);
    tbl.push_back('{v, d, fl, full, rdy, wv, wd, ww, idl});
  endtask

  // One scoreboard cycle: sample at the falling edge, then advance.
  task automatic sb_cycle(input logic v, input logic [7:0] d, input logic fl, input logic full);
    int ww;
    drive(v, d, fl, full);
    @(negedge clk);
    if (hold_prev) begin
      chk("hold.valid", {31'd0, bus.wr_valid}, 32'd1);
      chk("hold.data", {8'd0, bus.wr_data}, {8'd0, prev_data});
    end
    if (bus.s_valid && bus.s_ready) begin
      exp_q.push_back(bus.s_data);
      sent++;
    end
    if (bus.wr_valid && !bus.wr_full) begin
      ww = int'(bus.wr_words);
      chk("bundle.words_nonzero", {31'd0, (ww != 0)}, 32'd1);
      for (int i = 0; i < PK; i++) begin
        if (i < ww) begin
          if (exp_q.size() == 0) begin
            chk("bundle.underflow", 32'(exp_q.size()), 32'd1);
          end else begin
            chk("bundle.lane", {24'd0, bus.wr_data[i*DW +: DW]}, {24'd0, exp_q.pop_front()});
          end
        end else begin
          chk("bundle.pad", {24'd0, bus.wr_data[i*DW +: DW]}, 32'd0);
        end
      end
    end
    hold_prev = bus.wr_valid && bus.wr_full;
    prev_data = bus.wr_data;
    tick();
  endtask

  initial begin
    int cyc;
    nchk = 0;
    nerr = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.s_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("rst.wr_valid", {31'd0, bus.wr_valid}, 32'd0);
    chk("rst.wr_data", {8'd0, bus.wr_data}, 32'd0);
    chk("rst.wr_words", {30'd0, bus.wr_words}, 32'd0);
    chk("rst.idle", {31'd0, bus.idle}, 32'd1);
    bus.s_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // Back-to-back stream
    add(1, 8'h11, 0, 0, 1, 0, 24'h000000, 2'd0, 1);
    add(1, 8'h22, 0, 0, 1, 0, 24'h000000, 2'd0, 0);
    add(1, 8'h33, 0, 0, 1, 0, 24'h000000, 2'd0, 0);
    add(1, 8'h44, 0, 0, 1, 1, 24'h332211, 2'd3, 0);
    add(1, 8'h55, 0, 0, 1, 0, 24'h332211, 2'd3, 0);
    add(1, 8'h66, 0, 0, 1, 0, 24'h332211, 2'd3, 0);
    add(0, 8'h00, 0, 0, 1, 1, 24'h665544, 2'd3, 0);
    add(0, 8'h00, 0, 0, 1, 0, 24'h665544, 2'd3, 1);
    // FIFO full: second bundle staged, then released
    add(1, 8'h11, 0, 1, 1, 0, 24'h665544, 2'd3, 1);
    add(1, 8'h22, 0, 1, 1, 0, 24'h665544, 2'd3, 0);
    add(1, 8'h33, 0, 1, 1, 0, 24'h665544, 2'd3, 0);
    add(1, 8'h44, 0, 1, 1, 1, 24'h332211, 2'd3, 0);
    add(1, 8'h55, 0, 1, 1, 1, 24'h332211, 2'd3, 0);
    add(1, 8'h66, 0, 1, 1, 1, 24'h332211, 2'd3, 0);
    add(0, 8'h00, 0, 1, 0, 1, 24'h332211, 2'd3, 0);
    add(0, 8'h00, 0, 0, 0, 1, 24'h332211, 2'd3, 0);
    add(0, 8'h00, 0, 0, 1, 1, 24'h665544, 2'd3, 0);
    add(0, 8'h00, 0, 0, 1, 0, 24'h665544, 2'd3, 1);
    // Partial flush of two words
    add(1, 8'hA1, 0, 0, 1, 0, 24'h665544, 2'd3, 1);
    add(1, 8'hB2, 0, 0, 1, 0, 24'h665544, 2'd3, 0);
    add(0, 8'h00, 1, 0, 1, 0, 24'h665544, 2'd3, 0);
    add(0, 8'h00, 0, 0, 0, 0, 24'h665544, 2'd3, 0);
    add(0, 8'h00, 0, 0, 1, 1, 24'h00B2A1, 2'd2, 0);
    add(0, 8'h00, 0, 0, 1, 0, 24'h00B2A1, 2'd2, 1);
    // Flush with nothing staged
    add(0, 8'h00, 1, 0, 1, 0, 24'h00B2A1, 2'd2, 1);
    add(0, 8'h00, 0, 0, 0, 0, 24'h00B2A1, 2'd2, 0);
    add(0, 8'h00, 0, 0, 1, 0, 24'h00B2A1, 2'd2, 1);
    // Word accepted in the flush cycle is included
    add(1, 8'hC3, 1, 0, 1, 0, 24'h00B2A1, 2'd2, 1);
    add(0, 8'h00, 0, 0, 0, 0, 24'h00B2A1, 2'd2, 0);
    add(0, 8'h00, 0, 0, 1, 1, 24'h0000C3, 2'd1, 0);
    add(0, 8'h00, 0, 0, 1, 0, 24'h0000C3, 2'd1, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].v, tbl[k].d, tbl[k].fl, tbl[k].full);
      @(negedge clk);
      chk($sformatf("row%0d.s_ready", k), {31'd0, bus.s_ready}, {31'd0, tbl[k].e_rdy});
      chk($sformatf("row%0d.wr_valid", k), {31'd0, bus.wr_valid}, {31'd0, tbl[k].e_wv});
      chk($sformatf("row%0d.wr_data", k), {8'd0, bus.wr_data}, {8'd0, tbl[k].e_wd});
      chk($sformatf("row%0d.wr_words", k), {30'd0, bus.wr_words}, {30'd0, tbl[k].e_ww});
      chk($sformatf("row%0d.idle", k), {31'd0, bus.idle}, {31'd0, tbl[k].e_idle});
      tick();
    end

    // Reset mid-operation: output valid and two words staged
    drive(1'b1, 8'hE1, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hE2, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hE3, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hF1, 1'b0, 1'b1); tick();
    drive(1'b1, 8'hF2, 1'b0, 1'b1); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("mid.pre_valid", {31'd0, bus.wr_valid}, 32'd1);
    chk("mid.pre_idle", {31'd0, bus.idle}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid.rst_valid", {31'd0, bus.wr_valid}, 32'd0);
    chk("mid.rst_data", {8'd0, bus.wr_data}, 32'd0);
    chk("mid.rst_words", {30'd0, bus.wr_words}, 32'd0);
    chk("mid.rst_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("mid.rst_idle", {31'd0, bus.idle}, 32'd1);
    tick();
    rst_n = 1'b1;
    bus.wr_full = 1'b0;
    tick();
    @(negedge clk);
    chk("mid.no_stale_bundle", {31'd0, bus.wr_valid}, 32'd0);
    tick();
    drive(1'b1, 8'hD1, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hD2, 1'b0, 1'b0); tick();
    drive(1'b1, 8'hD3, 1'b0, 1'b0); tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid.clean_valid", {31'd0, bus.wr_valid}, 32'd1);
    chk("mid.clean_data", {8'd0, bus.wr_data}, 32'h00D3D2D1);
    chk("mid.clean_words", {30'd0, bus.wr_words}, 32'd3);
    tick();
    tick();

    // Random traffic against a scoreboard
    sent = 0;
    hold_prev = 1'b0;
    prev_data = 24'd0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      sb_cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
      cyc++;
    end
    chk("rand.sent", 32'(sent), 32'd1000);
    sb_cycle(1'b0, 8'h00, 1'b1, ($urandom_range(0, 3) == 0));
    cyc = 0;
    while (!(bus.idle && exp_q.size() == 0) && cyc < 200) begin
      sb_cycle(1'b0, 8'h00, 1'b0, 1'b0);
      cyc++;
    end
    chk("drain.empty", 32'(exp_q.size()), 32'd0);
    chk("drain.idle", {31'd0, bus.idle}, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fifo_bundle_packer.md
Name: fifo_bundle_packer

Overview:
- Write-side front end for the bundle FIFO.
- Takes single DATAWIDTH words from a valid/ready stream and packs PACK consecutive words into one bundle.
- Drives the FIFO write port (din/din_valid) and honours its full flag.
- Sits directly upstream of the FIFO; PACK equals the FIFO's input bundle size. Flush emits a zero-padded partial bundle at end of frame.

Parameters:
DATAWIDTH, 192, bits per word
PACK, 6, words per bundle (>=2); must equal FIFO input bundle size
CNT_WIDTH, $clog2(PACK+1), width of word counters

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
s_data  input  DATAWIDTH  incoming word
s_valid  input  1  s_data valid
s_ready  output  1  packer accepts s_data this cycle
flush  input  1  one-cycle pulse: emit any partial bundle
wr_data  output  DATAWIDTH*PACK  bundle to FIFO din; word 0 (oldest) in bits [DATAWIDTH-1:0]
wr_valid  output  1  bundle valid, to FIFO din_valid
wr_full  input  1  FIFO full flag
wr_words  output  CNT_WIDTH  number of real words in wr_data (PACK, or fewer after flush)
idle  output  1  no data held anywhere, no flush pending

Behaviour:
- Reset (async assert, sync release). Values:
  - s_ready=1, wr_valid=0, wr_data=0, wr_words=0, idle=1.
  - Staging counter stg_cnt=0, flush_pend=0.
  - Reset mid-operation discards all held words; no bundle is emitted afterwards.
- Storage: staging register (PACK words, count stg_cnt 0..PACK) plus one output register (wr_data/wr_words/wr_valid).
- Handshakes:
  - accept = s_valid & s_ready.
  - fire = wr_valid & !wr_full, which matches the FIFO write condition.
  - slot_free = !wr_valid | fire.
- s_ready = (stg_cnt < PACK) & !flush_pend.
- Accepted word is written to staging lane stg_cnt; stg_cnt increments.
- Last word (accept with stg_cnt==PACK-1):
  - If slot_free: the output register loads {s_data, staging lanes 0..PACK-2} at that edge. wr_valid=1 and wr_words=PACK next cycle. stg_cnt<=0.
  - Latency: 1 cycle from last accept to wr_valid. Full throughput of 1 word/cycle while FIFO not full.
  - Else: stg_cnt<=PACK and s_ready drops.
- Held full staging (stg_cnt==PACK): moves to the output register on the first cycle slot_free=1; stg_cnt<=0.
- Output register:
  - Holds wr_data/wr_words stable while wr_valid & wr_full.
  - On fire with no new load, wr_valid<=0; wr_data keeps its last value.
- Flush:
  - flush sets flush_pend; a word accepted in the same cycle as flush is included in the flushed bundle.
  - flush_pend & stg_cnt==0: clear flush_pend next edge; emit nothing.
  - flush_pend & 0<stg_cnt<PACK & slot_free: load output with the staged lanes, upper lanes zero; wr_words=stg_cnt; stg_cnt<=0; clear flush_pend.
  - flush_pend & stg_cnt==PACK: normal full move, then clear flush_pend.
  - Flush while already pending: no additional effect.
- Simultaneous cases:
  - Fire and load in the same cycle: wr_valid stays 1 with the new bundle.
  - Last-word accept while FIFO full: the word goes to staging; no data is lost or overwritten.
- idle = (stg_cnt==0) & !wr_valid & !flush_pend.
- Counters: CNT_WIDTH, no wrap; stg_cnt never exceeds PACK.
- Sequential logic uses the asynchronous active-low reset only; no synchronous clears other than state-machine updates.

Test Plan:
(PACK=3, DATAWIDTH=8 bench, wr_full=0 unless stated)
- Reset with s_valid=1 -> s_ready=1, wr_valid=0, wr_data=0, idle=1.
- Stream 0x11,0x22,0x33,0x44,0x55,0x66 back-to-back -> wr_valid one cycle after each 3rd accept. wr_data=0x332211 then 0x665544; wr_words=3; s_ready never drops.
- wr_full=1, stream 6 words:
  - wr_data=0x332211 held, words 4-6 staged, s_ready=0 after word 6.
  - Release wr_full -> 0x332211 fires, then 0x665544 next cycle, then s_ready=1.
- Send 0xA1,0xB2 then flush pulse -> wr_data=0x00B2A1, wr_words=2, one bundle only. Flush with stg_cnt==0 -> no wr_valid, idle=1 within 1 cycle.
- Assert rst_n=0 mid-bundle (2 words staged, output valid) -> outputs to reset values immediately. Next 3 words produce a clean bundle with no stale lanes.
- Random s_valid/wr_full, 1000 words -> scoreboard: order preserved, no loss/duplication, wr_data stable while wr_valid & wr_full.
